// File: rtl/vx_tcu_uop_sequencer.sv
// Purpose: expands one accepted TCU instruction into (in_steps+1) k-step dispatch beats and bounds in-flight instructions.
// Latency: accept in cycle N gives the first beat in N+1; an n-beat instruction ends in N+n with no backpressure.
// Backpressure: beats hold stable while out_ready is low; in_ready drops while issuing or when pending_cnt reaches MAX_PENDING.
module vx_tcu_uop_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int UUID_W      = 44,
  parameter int DATA_W      = 32,
  parameter int MAX_STEPS   = 8,
  parameter int MAX_PENDING = 4,
  parameter int STEP_W      = $clog2(MAX_STEPS),
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [UUID_W-1:0]             in_uuid,
  input  logic [NW_BITS-1:0]            in_wid,
  input  logic [NUM_THREADS-1:0]        in_tmask,
  input  logic [3:0]                    in_fmt,
  input  logic [4:0]                    in_rd,
  input  logic [STEP_W-1:0]             in_steps,
  input  logic [NUM_THREADS*DATA_W-1:0] in_rs1,
  input  logic [NUM_THREADS*DATA_W-1:0] in_rs2,
  input  logic [NUM_THREADS*DATA_W-1:0] in_rs3,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [UUID_W-1:0]             out_uuid,
  output logic [NW_BITS-1:0]            out_wid,
  output logic [NUM_THREADS-1:0]        out_tmask,
  output logic [3:0]                    out_fmt,
  output logic [4:0]                    out_rd,
  output logic [NUM_THREADS*DATA_W-1:0] out_rs1,
  output logic [NUM_THREADS*DATA_W-1:0] out_rs2,
  output logic [NUM_THREADS*DATA_W-1:0] out_rs3,
  output logic [STEP_W-1:0]             out_step,
  output logic                          out_sop,
  output logic                          out_eop,
  input  logic                          commit_valid,
  output logic [CNT_W-1:0]              pending_cnt,
  output logic                          busy,
  output logic                          err_underflow
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_PENDING);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] steps_q;
  logic              accept;
  logic              fire;
  logic              last_beat;

  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last_beat = (step == steps_q);

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: leave IDLE on accept, return once the final beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (fire && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; in_ready is forced low during reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = reset_n && (pending_cnt < CNT_MAX);
      ISSUE:   out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Capture instruction fields on accept and advance the k-step on each taken beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step      <= '0;
      steps_q   <= '0;
      out_uuid  <= '0;
      out_wid   <= '0;
      out_tmask <= '0;
      out_fmt   <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rs3   <= '0;
    end else if (accept) begin
      step      <= '0;
      steps_q   <= in_steps;
      out_uuid  <= in_uuid;
      out_wid   <= in_wid;
      out_tmask <= in_tmask;
      out_fmt   <= in_fmt;
      out_rd    <= in_rd;
      out_rs1   <= in_rs1;
      out_rs2   <= in_rs2;
      out_rs3   <= in_rs3;
    end else if (fire && !last_beat) begin
      step <= step + STEP_ONE;
    end
  end

  // In-flight count: accept and commit in the same cycle cancel; a commit with nothing pending is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({accept, commit_valid})
        2'b10: pending_cnt <= pending_cnt + CNT_ONE;
        2'b01: begin
          if (pending_cnt == '0) err_underflow <= 1'b1;
          else                   pending_cnt   <= pending_cnt - CNT_ONE;
        end
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  assign out_step = step;
  assign out_sop  = (step == '0);
  assign out_eop  = last_beat;
  assign busy     = (state == ISSUE) || (pending_cnt != '0);

endmodule
